// File: rtl/seven_segment_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seven_segment_scan_ctrl                                    |
// | Description : Time-multiplexed 7-segment scanner. NUM_DIGITS BCD digits  |
// |               share one segment bus, with a blanking gap before every    |
// |               digit. Loads are double-buffered (pending -> shadow) and   |
// |               only take effect at the frame wrap, so a frame never tears.|
// | Option      : SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN adds a 4-bit brightness   |
// |               input that PWM-gates the DRIVE window.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seven_segment_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load_valid,
`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
   input  logic [3:0]              brightness,
`endif
   output logic                    load_ready,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_tick
);

   localparam int c_IDX_W   = $clog2(NUM_DIGITS);
   localparam int c_MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int c_TMR_W   = $clog2(c_MAX_CYC) + 1;

   localparam logic [c_TMR_W-1:0] c_DWELL_LAST = c_TMR_W'(DWELL_CYCLES - 1);
   localparam logic [c_TMR_W-1:0] c_BLANK_LAST = c_TMR_W'(BLANK_CYCLES - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [c_IDX_W-1:0]      r_idx, w_idx_nxt;
   logic [c_TMR_W-1:0]      r_timer, w_timer_nxt;
   logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_nxt;
   logic [4*NUM_DIGITS-1:0] r_pending, w_pending_nxt;
   logic                    r_load_ready, w_ready_nxt;
   logic [6:0]              r_seg, w_seg_nxt;
   logic [NUM_DIGITS-1:0]   r_digit_en, w_en_nxt;
   logic                    r_frame_tick;
   logic                    w_wrap;
   logic                    w_drive_entry;
   logic                    w_accept;
   logic                    w_lit;
   logic [3:0]              w_nibble;

`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
   logic [3:0]              r_pwm, w_pwm_nxt;
   logic [3:0]              r_bright, w_bright_nxt;
`endif

   // BCD to {g,f,e,d,c,b,a}; non-decimal codes blank the digit
   function automatic logic [6:0] f_decode(input logic [3:0] val);
      case (val)
         4'd0:    f_decode = 7'b0111111;
         4'd1:    f_decode = 7'b0000110;
         4'd2:    f_decode = 7'b1011011;
         4'd3:    f_decode = 7'b1001111;
         4'd4:    f_decode = 7'b1100110;
         4'd5:    f_decode = 7'b1101101;
         4'd6:    f_decode = 7'b1111101;
         4'd7:    f_decode = 7'b0000111;
         4'd8:    f_decode = 7'b1111111;
         4'd9:    f_decode = 7'b1101111;
         default: f_decode = 7'b0000000;
      endcase
   endfunction

   // Next-state, handshake and next-output logic; outputs are computed from
   // next-state values so the registered outputs line up with the state
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_timer_nxt   = r_timer + 1'b1;
      w_wrap        = 1'b0;
      w_drive_entry = 1'b0;

      case (r_state)
         ST_BLANK: begin
            if (r_timer == c_BLANK_LAST) begin
               w_state_nxt   = ST_DRIVE;
               w_timer_nxt   = '0;
               w_drive_entry = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (r_timer == c_DWELL_LAST) begin
               w_state_nxt = ST_BLANK;
               w_timer_nxt = '0;
               if (r_idx == c_IDX_LAST) begin
                  w_idx_nxt = '0;
                  w_wrap    = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_BLANK;
            w_timer_nxt = '0;
            w_idx_nxt   = '0;
         end
      endcase

      // load_ready low means pending holds a value waiting for the wrap
      w_accept      = load_valid && r_load_ready;
      w_shadow_nxt  = r_shadow;
      w_pending_nxt = r_pending;
      w_ready_nxt   = r_load_ready;
      if (w_wrap) begin
         if (w_accept) begin
            w_shadow_nxt = digits_in;
         end else if (!r_load_ready) begin
            w_shadow_nxt = r_pending;
         end
         w_ready_nxt = 1'b1;
      end else if (w_accept) begin
         w_pending_nxt = digits_in;
         w_ready_nxt   = 1'b0;
      end

      w_nibble = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_idx_nxt == c_IDX_W'(i)) begin
            w_nibble = w_shadow_nxt[4*i +: 4];
         end
      end

`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
      w_bright_nxt = w_drive_entry ? brightness : r_bright;
      if (w_drive_entry || (w_state_nxt != ST_DRIVE)) begin
         w_pwm_nxt = 4'd0;
      end else begin
         w_pwm_nxt = (r_pwm == 4'd14) ? 4'd0 : r_pwm + 4'd1;
      end
      w_lit = (w_state_nxt == ST_DRIVE) && (w_pwm_nxt < w_bright_nxt);
`else
      w_lit = (w_state_nxt == ST_DRIVE);
`endif

      w_seg_nxt = w_lit ? f_decode(w_nibble) : 7'd0;
      w_en_nxt  = w_lit ? (NUM_DIGITS'(1) << w_idx_nxt) : '0;
   end

   // State, buffers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_BLANK;
         r_idx        <= '0;
         r_timer      <= '0;
         r_shadow     <= '0;
         r_pending    <= '0;
         r_load_ready <= 1'b1;
         r_seg        <= 7'd0;
         r_digit_en   <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_timer      <= w_timer_nxt;
         r_shadow     <= w_shadow_nxt;
         r_pending    <= w_pending_nxt;
         r_load_ready <= w_ready_nxt;
         r_seg        <= w_seg_nxt;
         r_digit_en   <= w_en_nxt;
         r_frame_tick <= w_wrap;
      end
   end

`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
   // PWM phase and brightness latched for the current dwell
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pwm    <= 4'd0;
         r_bright <= 4'd0;
      end else begin
         r_pwm    <= w_pwm_nxt;
         r_bright <= w_bright_nxt;
      end
   end
`endif

   assign load_ready = r_load_ready;
   assign seg_out    = r_seg;
   assign digit_en   = r_digit_en;
   assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seven_segment_scan_ctrl                                 |
// | Description : Scoreboard bench for seven_segment_scan_ctrl with          |
// |               NUM_DIGITS=4, DWELL=4, BLANK=2 (frame = 24 cycles).        |
// |               Expected per-cycle outputs are queued by the stimulus and  |
// |               popped by an independent monitor on the falling edge.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seven_segment_scan_ctrl;

   localparam int c_ND = 4;
   localparam int c_DW = 4;
   localparam int c_BL = 2;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic [15:0] digits_in  = 16'h0000;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [6:0]  seg_out;
   logic [3:0]  digit_en;
   logic        frame_tick;
`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
   logic [3:0]  brightness = 4'd15;
`endif

   seven_segment_scan_ctrl #(
      .NUM_DIGITS   (c_ND),
      .DWELL_CYCLES (c_DW),
      .BLANK_CYCLES (c_BL)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .digits_in  (digits_in),
      .load_valid (load_valid),
`ifdef SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .load_ready (load_ready),
      .seg_out    (seg_out),
      .digit_en   (digit_en),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] en;
      logic [6:0] seg;
      logic       tick;
      logic       rdy;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   started  = 1'b0;
   logic prev_tick = 1'b0;

   // Cycle number: 0 is the first cycle after the last reset edge
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp_v);
   endtask

   task automatic expect_at(input int c, input logic [3:0] en, input logic [6:0] seg,
                            input logic tick, input logic rdy);
      exp_t e;
      e.cyc = c; e.en = en; e.seg = seg; e.tick = tick; e.rdy = rdy;
      q.push_back(e);
   endtask

   task automatic go_to(input int c);
      int guard;
      guard = 0;
      while (cyc != c) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 500) begin
            $display("FAIL go_to timeout: cycle %0d expected %0d", cyc, c);
            $display("%0d/%0d checks passed", n_pass, n_checks + 1);
            $fatal(1, "timeout");
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (q.size() > 0) begin
         check("drain_left", q.size(), 0);
         q.delete();
      end
   endtask

   // Monitor: invariants every cycle, scoreboard pops on matching cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (started) begin
            check("onehot0", 32'($onehot0(digit_en)), 32'd1);
            if (digit_en == 4'd0) check("seg_when_off", seg_out, 0);
            if (prev_tick) check("tick_width", frame_tick, 0);
            prev_tick = frame_tick;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
               e = q.pop_front();
               if (e.cyc < cyc) begin
                  check("missed_entry", cyc, e.cyc);
               end else begin
                  check("digit_en",   digit_en,   e.en);
                  check("seg_out",    seg_out,    e.seg);
                  check("frame_tick", frame_tick, e.tick);
                  check("load_ready", load_ready, e.rdy);
               end
            end
         end
      end
   end

   // Stimulus and hand-computed expectations
   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset   = 1'b0;
      started = 1'b1;

      // Frame 0: shadow=0 (digit shows 0); load 4321 at 5, 0B85 held from 10
      expect_at( 0, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at( 1, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at( 2, 4'b0001, 7'h3F, 1'b0, 1'b1);
      expect_at( 5, 4'b0001, 7'h3F, 1'b0, 1'b1);
      expect_at( 6, 4'b0000, 7'h00, 1'b0, 1'b0);
      expect_at( 7, 4'b0000, 7'h00, 1'b0, 1'b0);
      expect_at( 8, 4'b0010, 7'h3F, 1'b0, 1'b0);
      expect_at(11, 4'b0010, 7'h3F, 1'b0, 1'b0);
      expect_at(12, 4'b0000, 7'h00, 1'b0, 1'b0);
      expect_at(14, 4'b0100, 7'h3F, 1'b0, 1'b0);
      expect_at(20, 4'b1000, 7'h3F, 1'b0, 1'b0);
      expect_at(23, 4'b1000, 7'h3F, 1'b0, 1'b0);
      // Frame 1: shows 4321; held 0B85 accepted at end of 24
      expect_at(24, 4'b0000, 7'h00, 1'b1, 1'b1);
      expect_at(25, 4'b0000, 7'h00, 1'b0, 1'b0);
      expect_at(26, 4'b0001, 7'h06, 1'b0, 1'b0);
      expect_at(32, 4'b0010, 7'h5B, 1'b0, 1'b0);
      expect_at(38, 4'b0100, 7'h4F, 1'b0, 1'b0);
      expect_at(44, 4'b1000, 7'h66, 1'b0, 1'b0);
      expect_at(47, 4'b1000, 7'h66, 1'b0, 1'b0);
      // Frame 2: shows 0B85, digit 2 = B is blank but still enabled
      expect_at(48, 4'b0000, 7'h00, 1'b1, 1'b1);
      expect_at(49, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at(50, 4'b0001, 7'h6D, 1'b0, 1'b1);
      expect_at(56, 4'b0010, 7'h7F, 1'b0, 1'b1);
      expect_at(62, 4'b0100, 7'h00, 1'b0, 1'b1);
      expect_at(65, 4'b0100, 7'h00, 1'b0, 1'b1);
      expect_at(66, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at(68, 4'b1000, 7'h3F, 1'b0, 1'b1);
      expect_at(71, 4'b1000, 7'h3F, 1'b0, 1'b1);
      // Frame 3: 2109 loaded on the wrap edge goes straight to shadow
      expect_at(72, 4'b0000, 7'h00, 1'b1, 1'b1);
      expect_at(73, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at(74, 4'b0001, 7'h6F, 1'b0, 1'b1);
      expect_at(80, 4'b0010, 7'h3F, 1'b0, 1'b1);
      expect_at(81, 4'b0010, 7'h3F, 1'b0, 1'b0);
      expect_at(86, 4'b0100, 7'h06, 1'b0, 1'b0);
      expect_at(87, 4'b0100, 7'h06, 1'b0, 1'b0);

      go_to(5);  load_valid = 1'b1; digits_in = 16'h4321;
      go_to(6);  load_valid = 1'b0;
      go_to(10); load_valid = 1'b1; digits_in = 16'h0B85;
      go_to(25); load_valid = 1'b0;
      go_to(71); load_valid = 1'b1; digits_in = 16'h2109;
      go_to(72); load_valid = 1'b0;
      go_to(80); load_valid = 1'b1; digits_in = 16'h5555;
      go_to(81); load_valid = 1'b0;

      // Reset during DRIVE of digit 2 with a load pending
      go_to(87);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      drain();

      // After reset: shadow and pending cleared, scan restarts at digit 0
      expect_at( 0, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at( 1, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at( 2, 4'b0001, 7'h3F, 1'b0, 1'b1);
      expect_at( 5, 4'b0001, 7'h3F, 1'b0, 1'b1);
      expect_at( 6, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at(23, 4'b1000, 7'h3F, 1'b0, 1'b1);
      expect_at(24, 4'b0000, 7'h00, 1'b1, 1'b1);
      expect_at(25, 4'b0000, 7'h00, 1'b0, 1'b1);
      expect_at(26, 4'b0001, 7'h3F, 1'b0, 1'b1);
      drain();

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment bus, with one-hot digit enables and a blanking gap between digits to prevent ghosting. Digit values arrive through a valid/ready load port. They are double-buffered and applied only at frame boundaries, so the display never tears. The block sits between the seconds/digit counters and the display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DWELL_CYCLES, 1000, cycles each digit is driven per frame (>=1)
BLANK_CYCLES, 16, cycles all outputs are off before each digit (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
digits_in  input  4*NUM_DIGITS  digit values; nibble i drives digit i
load_valid  input  1  digits_in valid
load_ready  output  1  block can accept a load
seg_out  output  7  segments, active-high, bit order {g,f,e,d,c,b,a}
digit_en  output  NUM_DIGITS  one-hot digit select, active-high
frame_tick  output  1  one-cycle pulse at frame wrap

Behaviour:
- All outputs are registered.
- Reset values:
  - state=BLANK, idx=0, timer=0
  - seg_out=0, digit_en=0, frame_tick=0, load_ready=1
  - shadow and pending registers = 0
- Reset behaves identically mid-operation: outputs go to their reset values on the next edge.
- FSM states: BLANK, DRIVE.
  - BLANK: seg_out=0, digit_en=0 for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: digit_en = 1<<idx and seg_out = decode(shadow[idx]) for DWELL_CYCLES cycles, then go to BLANK.
  - On DRIVE exit: idx increments. If idx==NUM_DIGITS-1, idx wraps to 0 and frame_tick=1 for exactly one cycle (the first BLANK cycle of the new frame).
- Timing, with cycle 0 = first cycle with reset low:
  - digit_en[0] is first high in cycle BLANK_CYCLES.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Decode:
  - 0..9 map to standard patterns (0 -> 7'b0111111, 1 -> 7'b0000110, 8 -> 7'b1111111).
  - Values 10..15 give 7'b0000000 (blank digit).
- Load handshake:
  - Transfer occurs when load_valid && load_ready at a clock edge. digits_in goes to pending, and load_ready=0 from the next cycle.
  - At the wrap edge, pending is copied to shadow and load_ready returns to 1.
  - A transfer on the wrap edge itself bypasses pending: digits_in goes straight to shadow and load_ready stays 1.
  - load_valid while load_ready=0 is ignored, and the producer holds it.
  - A digit value never changes while its digit_en is high.
- Invariants:
  - digit_en is one-hot or zero.
  - seg_out==0 whenever digit_en==0.
  - idx < NUM_DIGITS.
  - frame_tick is never high on two consecutive cycles.

Optional Feature:
Macro SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input brightness[3:0].
  - A 4-bit pwm counter runs 0..14, restarting at 0 on entry to DRIVE and wrapping within DRIVE.
  - In DRIVE, digit_en and seg_out are forced to 0 whenever pwm >= brightness.
  - brightness=0 means dark; brightness=15 means always on.
  - brightness is sampled at DRIVE entry and held for that dwell.
- When undefined: there is no brightness port and DRIVE is always fully on.
- FSM timing and the handshake are identical in both builds.

Test Plan:
- Reset, then release with NUM_DIGITS=4, DWELL=4, BLANK=2:
  - Outputs stay 0 in cycles 0-1.
  - digit_en=4'b0001 in cycles 2-5, 4'b0010 in cycles 8-11.
  - frame_tick pulses in cycle 24.
- Load digits_in=16'h4321 at cycle 5, mid-frame:
  - load_ready=0 from cycle 6 until the wrap.
  - Digit 0 shows 7'b0111111 until the wrap, then 7'b0000110 (digit 1 pattern) in the next frame.
- Load asserted exactly on the wrap edge: the new values appear in the immediately following frame, and load_ready never drops.
- Load digit value 4'hB: seg_out=0 during that digit's DRIVE window while digit_en is still asserted.
- Reset asserted mid-DRIVE of digit 2: the next cycle has digit_en=0, seg_out=0, load_ready=1, shadow=0, and the scan restarts at digit 0 after BLANK.
- With SEVEN_SEGMENT_SCAN_BRIGHTNESS_EN, DWELL=30, brightness=5: digit_en is high 5 of every 15 DRIVE cycles (10 of 30). brightness=0 gives no enables; brightness=15 gives a full dwell.
